// File: rtl/sigma_pkg.sv
// Shared constants for the SHA-256 sigma sequencer: select encodings, FSM states,
// and the per-function rotate/shift amount table.
package sigma_pkg;

   localparam logic [1:0] SEL_BSIG0 = 2'd0;
   localparam logic [1:0] SEL_BSIG1 = 2'd1;
   localparam logic [1:0] SEL_SSIG0 = 2'd2;
   localparam logic [1:0] SEL_SSIG1 = 2'd3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      R0   = 3'd1,
      R1   = 3'd2,
      R2   = 3'd3,
      DONE = 3'd4
   } state_e;

   // Right-rotate (or right-shift, on a SHR pass) amount for each function and pass.
   function automatic logic [4:0] rotr_amt(input logic [1:0] sel, input logic [1:0] pass);
      logic [4:0] amt;
      amt = 5'd0;
      case (sel)
         SEL_BSIG0: case (pass) 2'd0: amt = 5'd2;  2'd1: amt = 5'd13; default: amt = 5'd22; endcase
         SEL_BSIG1: case (pass) 2'd0: amt = 5'd6;  2'd1: amt = 5'd11; default: amt = 5'd25; endcase
         SEL_SSIG0: case (pass) 2'd0: amt = 5'd7;  2'd1: amt = 5'd18; default: amt = 5'd3;  endcase
         default:   case (pass) 2'd0: amt = 5'd17; 2'd1: amt = 5'd19; default: amt = 5'd10; endcase
      endcase
      return amt;
   endfunction

   // Only the third pass of the small sigmas is a logical shift.
   function automatic logic pass_is_shr(input logic [1:0] sel, input logic [1:0] pass);
      return (sel == SEL_SSIG0 || sel == SEL_SSIG1) && (pass == 2'd2);
   endfunction

endpackage

// File: rtl/rotl32.sv
// Combinational 32-bit rotate-left; an amount of 0 passes the word through unchanged.
module rotl32 (
   input  logic [31:0] word,
   input  logic [4:0]  amt,
   output logic [31:0] rot
);

   logic [63:0] dbl;

   // Shifting a doubled copy leaves the rotated word in the upper half.
   assign dbl = {word, word} << amt;
   assign rot = dbl[63:32];

endmodule

// File: rtl/sigma_seq.sv
// SHA-256 sigma evaluator: three passes through one shared left-rotator, XOR-accumulated.
// Optional completed-operation counter on op_count when SIGMA_SEQ_CNT_EN is defined.
module sigma_seq
   import sigma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   input  logic [1:0]  in_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
`ifdef SIGMA_SEQ_CNT_EN
   ,
   output logic [15:0] op_count
`endif
);

   state_e      state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] acc_q, acc_d;

   logic [1:0]  pass;
   logic [4:0]  rotr_n;
   logic [4:0]  rotl_n;
   logic [31:0] rot_out;
   logic [31:0] pass_word;

   always_comb begin
      case (state_q)
         R1:      pass = 2'd1;
         R2:      pass = 2'd2;
         default: pass = 2'd0;
      endcase
   end

   assign rotr_n = rotr_amt(sel_q, pass);
   // ROTR n equals ROTL (32-n) mod 32; 5-bit wraparound does the modulo.
   assign rotl_n = 5'd0 - rotr_n;

   rotl32 u_rotl32 (
      .word (word_q),
      .amt  (rotl_n),
      .rot  (rot_out)
   );

   assign pass_word = pass_is_shr(sel_q, pass) ? (rot_out & (32'hFFFF_FFFF >> rotr_n)) : rot_out;

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      sel_d     = sel_q;
      acc_d     = acc_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_word;
               sel_d   = in_sel;
               acc_d   = 32'd0;
               state_d = R0;
            end
         end
         R0: begin
            acc_d   = acc_q ^ pass_word;
            state_d = R1;
         end
         R1: begin
            acc_d   = acc_q ^ pass_word;
            state_d = R2;
         end
         R2: begin
            acc_d   = acc_q ^ pass_word;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data = acc_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= 32'd0;
         sel_q   <= 2'd0;
         acc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
      end
   end

`ifdef SIGMA_SEQ_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 16'd0;
      else        cnt_q <= cnt_d;
   end

   assign op_count = cnt_q;
`endif

endmodule
